// File: rtl/ic_hc_ac_lut_if.sv
// rtl/ic_hc_ac_lut_if.sv - load port and lookup pipeline bundle for ic_hc_ac_lut
//
// Purpose : groups the table load port, the per-table loaded flags and the
//           request/result valid/ready handshakes of the AC code lookup.
// Modports: master - drives loads and requests, consumes results
//           slave  - the lookup block itself
// Signals : ld_valid/ld_tsel/ld_addr/ld_data/ld_done  table writes and load marks
//           tbl_loaded                               per-table loaded flags
//           in_valid/in_ready/in_tsel/in_run/in_size lookup request
//           out_valid/out_ready/out_code/out_len/out_err lookup result
interface ic_hc_ac_lut_if #(
  parameter int NUM_TABLES = 2,
  parameter int CODE_W     = 16,
  parameter int LEN_W      = 5
);
  localparam int TSEL_W = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;

  logic                    ld_valid;
  logic [TSEL_W-1:0]       ld_tsel;
  logic [7:0]              ld_addr;
  logic [CODE_W+LEN_W-1:0] ld_data;
  logic                    ld_done;
  logic [NUM_TABLES-1:0]   tbl_loaded;

  logic                    in_valid;
  logic                    in_ready;
  logic [TSEL_W-1:0]       in_tsel;
  logic [3:0]              in_run;
  logic [3:0]              in_size;

  logic                    out_valid;
  logic                    out_ready;
  logic [CODE_W-1:0]       out_code;
  logic [LEN_W-1:0]        out_len;
  logic                    out_err;

  modport master (
    output ld_valid, ld_tsel, ld_addr, ld_data, ld_done,
    input  tbl_loaded,
    output in_valid, in_tsel, in_run, in_size,
    input  in_ready,
    input  out_valid, out_code, out_len, out_err,
    output out_ready
  );

  modport slave (
    input  ld_valid, ld_tsel, ld_addr, ld_data, ld_done,
    output tbl_loaded,
    input  in_valid, in_tsel, in_run, in_size,
    output in_ready,
    output out_valid, out_code, out_len, out_err,
    input  out_ready
  );
endinterface

// File: rtl/ic_hc_ac_lut.sv
// rtl/ic_hc_ac_lut.sv - runtime-loadable Huffman AC code lookup, 2-stage valid/ready pipeline
//
// Purpose : holds NUM_TABLES AC tables indexed by {run, size}; returns the
//           right-aligned {code, length} for each request two cycles after
//           acceptance, with backpressure from out_ready.
// Ports   : clock - rising-edge clock
//           reset - synchronous active-high reset
//           bus   - ic_hc_ac_lut_if.slave (load port, loaded flags, request, result)
module ic_hc_ac_lut #(
  parameter int NUM_TABLES = 2,
  parameter int CODE_W     = 16,
  parameter int LEN_W      = 5,
  parameter int MAX_SIZE   = 10
) (
  input logic            clock,
  input logic            reset,
  ic_hc_ac_lut_if.slave  bus
);
  localparam int TSEL_W = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
  localparam int ENT_W  = CODE_W + LEN_W;
  localparam int DEPTH  = NUM_TABLES * 256;

  localparam logic [TSEL_W:0] NUM_TABLES_L = (TSEL_W + 1)'(NUM_TABLES);
  localparam logic [3:0]      MAX_SIZE_L   = 4'(MAX_SIZE);
  localparam logic [LEN_W:0]  CODE_W_L     = (LEN_W + 1)'(CODE_W);

  // Table storage; deliberately not reset, tables are reloaded after reset.
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] rdata_q;

  logic [NUM_TABLES-1:0] loaded_q, loaded_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q, s1_err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_err_q, out_err_d;
  logic [CODE_W-1:0]     out_code_q, out_code_d;
  logic [LEN_W-1:0]      out_len_q, out_len_d;

  logic              en;
  logic              ld_tsel_ok, in_tsel_ok, in_loaded, in_bad_size;
  logic [CODE_W-1:0] s2_code;
  logic [LEN_W-1:0]  s2_len;
  logic              s2_err;

  // Both stages advance together: whenever the output slot is free or being taken.
  assign en = ~out_valid_q | bus.out_ready;

  assign ld_tsel_ok = ({1'b0, bus.ld_tsel} < NUM_TABLES_L);
  assign in_tsel_ok = ({1'b0, bus.in_tsel} < NUM_TABLES_L);
  assign in_loaded  = in_tsel_ok && loaded_q[bus.in_tsel];
  // size 0 is only legal as EOB (run 0) or ZRL (run 15).
  assign in_bad_size = (bus.in_size > MAX_SIZE_L) ||
                       ((bus.in_size == 4'd0) && (bus.in_run != 4'd0) && (bus.in_run != 4'hF));

  // Nonblocking read and write on the same edge give read-before-write on a collision.
  always_ff @(posedge clock) begin
    if (bus.ld_valid && ld_tsel_ok) begin
      mem_q[{bus.ld_tsel, bus.ld_addr}] <= bus.ld_data;
    end
    if (en) begin
      rdata_q <= mem_q[{bus.in_tsel, bus.in_run, bus.in_size}];
    end
  end

  assign s2_code = rdata_q[ENT_W-1:LEN_W];
  assign s2_len  = rdata_q[LEN_W-1:0];
  assign s2_err  = s1_err_q || (s2_len == '0) || ({1'b0, s2_len} > CODE_W_L);

  always_comb begin
    loaded_d    = loaded_q;
    s1_valid_d  = s1_valid_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_code_d  = out_code_q;
    out_len_d   = out_len_q;

    if (bus.ld_done && ld_tsel_ok) begin
      loaded_d[bus.ld_tsel] = 1'b1;
    end

    if (en) begin
      s1_valid_d  = bus.in_valid;
      s1_err_d    = ~in_tsel_ok | ~in_loaded | in_bad_size;
      out_valid_d = s1_valid_q;
      out_err_d   = s1_valid_q & s2_err;
      out_code_d  = (s1_valid_q && !s2_err) ? s2_code : '0;
      out_len_d   = (s1_valid_q && !s2_err) ? s2_len  : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      loaded_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_code_q  <= '0;
      out_len_q   <= '0;
    end else begin
      loaded_q    <= loaded_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_code_q  <= out_code_d;
      out_len_q   <= out_len_d;
    end
  end

  assign bus.in_ready   = en;
  assign bus.tbl_loaded = loaded_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_code   = out_code_q;
  assign bus.out_len    = out_len_q;
endmodule

// File: tb/tb_ic_hc_ac_lut.sv
// tb/tb_ic_hc_ac_lut.sv - scoreboard testbench for ic_hc_ac_lut
module tb_ic_hc_ac_lut;
  typedef struct {
    logic [15:0] code;
    logic [4:0]  len;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   rx    = 0;
  exp_t sb[$];

  ic_hc_ac_lut_if bus_if ();

  ic_hc_ac_lut dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on every output handshake and watches stalls.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_code;
  logic [4:0]  prev_len;
  logic        prev_err;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", bus_if.out_valid, 1'b1);
        chk("stall_code_hold", bus_if.out_code, prev_code);
        chk("stall_len_hold", bus_if.out_len, prev_len);
        chk("stall_err_hold", bus_if.out_err, prev_err);
      end
      if (bus_if.out_valid && !bus_if.out_ready) begin
        chk("in_ready_low_when_stalled", bus_if.in_ready, 1'b0);
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        chk("result_expected", (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_code", bus_if.out_code, e.code);
          chk("out_len", bus_if.out_len, e.len);
          chk("out_err", bus_if.out_err, e.err);
          rx++;
        end
      end
      prev_stall = bus_if.out_valid && !bus_if.out_ready;
      prev_code  = bus_if.out_code;
      prev_len   = bus_if.out_len;
      prev_err   = bus_if.out_err;
    end
  end

  task automatic ld_write(input logic tsel, input logic [7:0] addr,
                          input logic [15:0] code, input logic [4:0] len);
    bus_if.ld_valid = 1'b1;
    bus_if.ld_tsel  = tsel;
    bus_if.ld_addr  = addr;
    bus_if.ld_data  = {code, len};
    @(posedge clock); #1;
    bus_if.ld_valid = 1'b0;
  endtask

  task automatic ld_mark(input logic tsel);
    bus_if.ld_done = 1'b1;
    bus_if.ld_tsel = tsel;
    @(posedge clock); #1;
    bus_if.ld_done = 1'b0;
  endtask

  task automatic lookup(input logic tsel, input logic [3:0] run, input logic [3:0] size,
                        input logic [15:0] ecode, input logic [4:0] elen, input logic eerr);
    int n = 0;
    exp_t e;
    bus_if.in_valid = 1'b1;
    bus_if.in_tsel  = tsel;
    bus_if.in_run   = run;
    bus_if.in_size  = size;
    @(negedge clock);
    while (!bus_if.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("lookup_accepted", bus_if.in_ready, 1'b1);
    if (bus_if.in_ready) begin
      e.code = ecode;
      e.len  = elen;
      e.err  = eerr;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    bus_if.in_valid = 1'b0;
    bus_if.ld_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(posedge clock); #1;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    logic [3:0] pat;
    int idx, cyc, rx0;
    exp_t e;

    bus_if.ld_valid  = 1'b0;
    bus_if.ld_tsel   = 1'b0;
    bus_if.ld_addr   = 8'h00;
    bus_if.ld_data   = '0;
    bus_if.ld_done   = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_tsel   = 1'b0;
    bus_if.in_run    = 4'h0;
    bus_if.in_size   = 4'h0;
    bus_if.out_ready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_out_valid", bus_if.out_valid, 1'b0);
    chk("reset_tbl_loaded", bus_if.tbl_loaded, 2'b00);
    chk("reset_out_code", bus_if.out_code, 16'h0);
    chk("reset_out_err", bus_if.out_err, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: load table 0 {0,1}, check latency and loaded flags
    ld_write(1'b0, 8'h01, 16'h0000, 5'd2);
    ld_mark(1'b0);
    chk("tbl_loaded_t0", bus_if.tbl_loaded, 2'b01);
    lookup(1'b0, 4'd0, 4'd1, 16'h0000, 5'd2, 1'b0);
    @(negedge clock);
    chk("latency_n_plus_1_not_valid", bus_if.out_valid, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("latency_n_plus_2_valid", bus_if.out_valid, 1'b1);
    @(posedge clock); #1;
    drain();

    // 2: table 1 before and after ld_done
    lookup(1'b1, 4'd0, 4'd1, 16'h0000, 5'd0, 1'b1);
    drain();
    ld_write(1'b1, 8'h01, 16'h0001, 5'd2);
    ld_mark(1'b1);
    chk("tbl_loaded_both", bus_if.tbl_loaded, 2'b11);
    lookup(1'b1, 4'd0, 4'd1, 16'h0001, 5'd2, 1'b0);
    drain();

    // 3: eight back-to-back requests under out_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      ld_write(1'b0, {4'(i + 1), 4'd2}, 16'h0100 + 16'(i), 5'(5 + i));
      ld_write(1'b1, {4'(i + 1), 4'd2}, 16'h0200 + 16'(i), 5'(5 + i));
    end
    pat = 4'b1001;
    idx = 0;
    cyc = 0;
    rx0 = rx;
    while ((idx < 8 || sb.size() > 0) && cyc < 200) begin
      bus_if.out_ready = pat[cyc % 4];
      if (idx < 8) begin
        bus_if.in_valid = 1'b1;
        bus_if.in_tsel  = idx[0];
        bus_if.in_run   = 4'(idx + 1);
        bus_if.in_size  = 4'd2;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      @(negedge clock);
      if (bus_if.in_valid && bus_if.in_ready) begin
        e.code = (idx[0] ? 16'h0200 : 16'h0100) + 16'(idx);
        e.len  = 5'(5 + idx);
        e.err  = 1'b0;
        sb.push_back(e);
        idx++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    chk("stream_all_issued", idx, 8);
    drain();
    chk("stream_results_count", rx - rx0, 8);

    // 4: illegal inputs and ZRL
    lookup(1'b0, 4'd3, 4'd0, 16'h0000, 5'd0, 1'b1);
    ld_write(1'b0, 8'hF0, 16'h07F9, 5'd11);
    lookup(1'b0, 4'd15, 4'd0, 16'h07F9, 5'd11, 1'b0);
    ld_write(1'b0, 8'h0B, 16'h0003, 5'd4);
    lookup(1'b0, 4'd0, 4'd11, 16'h0000, 5'd0, 1'b1);
    ld_write(1'b0, 8'h23, 16'h0005, 5'd0);
    lookup(1'b0, 4'd2, 4'd3, 16'h0000, 5'd0, 1'b1);
    ld_write(1'b0, 8'h24, 16'h0005, 5'd17);
    lookup(1'b0, 4'd2, 4'd4, 16'h0000, 5'd0, 1'b1);
    ld_write(1'b0, 8'h25, 16'hFFFF, 5'd16);
    lookup(1'b0, 4'd2, 4'd5, 16'hFFFF, 5'd16, 1'b0);
    drain();

    // 5: write and lookup of the same entry in one cycle returns old data
    bus_if.ld_valid = 1'b1;
    bus_if.ld_tsel  = 1'b0;
    bus_if.ld_addr  = 8'h01;
    bus_if.ld_data  = {16'h0001, 5'd3};
    lookup(1'b0, 4'd0, 4'd1, 16'h0000, 5'd2, 1'b0);
    lookup(1'b0, 4'd0, 4'd1, 16'h0001, 5'd3, 1'b0);
    drain();

    // 6: reset with two results in flight
    bus_if.out_ready = 1'b0;
    lookup(1'b0, 4'd0, 4'd1, 16'h0001, 5'd3, 1'b0);
    lookup(1'b1, 4'd0, 4'd1, 16'h0001, 5'd2, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    @(negedge clock);
    chk("reset_flush_out_valid", bus_if.out_valid, 1'b0);
    chk("reset_flush_tbl_loaded", bus_if.tbl_loaded, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_reset_no_output", bus_if.out_valid, 1'b0);
      @(posedge clock); #1;
    end
    lookup(1'b0, 4'd0, 4'd1, 16'h0000, 5'd0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
